// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CR16-style multi-cycle controller:
// states, opcode/ext fields, datapath selects and condition codes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_STORE  = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_SHIFT, K_LUI, K_LOAD,
    K_STOR, K_JCOND, K_BCOND, K_ILL
  } kind_t;

  localparam logic [3:0] OP_REG    = 4'b0000;
  localparam logic [3:0] FN_AND    = 4'b0001;
  localparam logic [3:0] FN_OR     = 4'b0010;
  localparam logic [3:0] FN_XOR    = 4'b0011;
  localparam logic [3:0] FN_ADD    = 4'b0101;
  localparam logic [3:0] FN_SUB    = 4'b1001;
  localparam logic [3:0] FN_CMP    = 4'b1011;
  localparam logic [3:0] FN_MOV    = 4'b1101;
  localparam logic [3:0] OP_LUI    = 4'b1111;
  localparam logic [3:0] OP_SHIFT  = 4'b1000;
  localparam logic [3:0] OP_LDST   = 4'b0100;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_LSH   = 4'b0100;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_ADD = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd9;
  localparam logic [3:0] ALU_CMP = 4'd11;
  localparam logic [3:0] ALU_MOV = 4'd13;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_SHF = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;
  localparam logic [1:0] WB_LUI = 2'b11;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_DISP = 2'b01;
  localparam logic [1:0] PC_REG  = 2'b10;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  function automatic logic is_alu_fn(input logic [3:0] fn);
    return fn inside {FN_AND, FN_OR, FN_XOR, FN_ADD,
                      FN_SUB, FN_CMP, FN_MOV};
  endfunction

  function automatic logic is_arith(input logic [3:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_CMP};
  endfunction

  function automatic logic [3:0] alu_code(input logic [3:0] fn);
    logic [3:0] c;
    c = ALU_NOP;
    case (fn)
      FN_AND:  c = ALU_AND;
      FN_OR:   c = ALU_OR;
      FN_XOR:  c = ALU_XOR;
      FN_ADD:  c = ALU_ADD;
      FN_SUB:  c = ALU_SUB;
      FN_CMP:  c = ALU_CMP;
      FN_MOV:  c = ALU_MOV;
      default: c = ALU_NOP;
    endcase
    return c;
  endfunction

  function automatic kind_t decode_kind(input logic [15:0] ir);
    logic [3:0] op;
    logic [3:0] ext;
    kind_t k;
    op  = ir[15:12];
    ext = ir[7:4];
    k   = K_ILL;
    case (op)
      OP_REG:   if (is_alu_fn(ext)) k = K_ALU;
      OP_LUI:   k = K_LUI;
      OP_BCOND: k = K_BCOND;
      OP_SHIFT:
        if (ext == EXT_LSH || ext[3:1] == 3'b000) k = K_SHIFT;
      OP_LDST:
        case (ext)
          EXT_LOAD:  k = K_LOAD;
          EXT_STOR:  k = K_STOR;
          EXT_JCOND: k = K_JCOND;
          default:   k = K_ILL;
        endcase
      default:  if (is_alu_fn(op)) k = K_ALU;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// CR16 branch condition evaluator: (cond, {C,L,F,Z,N}) -> take.
// Purely combinational.
import cpu_ctrl_pkg::*;

module cond_eval (
  input  logic [3:0] i_cond,
  input  logic [4:0] i_flags,
  output logic       o_take
);

  logic w_c, w_l, w_f, w_z, w_n;

  assign {w_c, w_l, w_f, w_z, w_n} = i_flags;

  always_comb begin
    o_take = 1'b0;
    case (i_cond)
      CC_EQ:   o_take = w_z;
      CC_NE:   o_take = !w_z;
      CC_CS:   o_take = w_c;
      CC_CC:   o_take = !w_c;
      CC_HI:   o_take = w_l;
      CC_LS:   o_take = !w_l;
      CC_GT:   o_take = w_n;
      CC_LE:   o_take = !w_n;
      CC_FS:   o_take = w_f;
      CC_FC:   o_take = !w_f;
      CC_LO:   o_take = !w_l && !w_z;
      CC_HS:   o_take = w_l || w_z;
      CC_LT:   o_take = !w_n && !w_z;
      CC_GE:   o_take = w_n || w_z;
      CC_UC:   o_take = 1'b1;
      default: o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 16-bit CR16-style datapath.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined encodings halt in S_HALT.
import cpu_ctrl_pkg::*;

module cpu_controller #(
  parameter int OP_W   = 4,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       ir,
  input  logic [FLAG_W-1:0] flags,
  output logic              ir_en,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              addr_sel,
  output logic              mem_we,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic [OP_W-1:0]   alu_op,
  output logic              b_sel,
  output logic              sign_ext,
  output logic              shift_dir,
  output logic              shift_amt_sel,
  output logic              flags_we,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic              illegal,
`endif
  output logic [2:0]        state
);

  state_t          r_state;
  state_t          w_next;
  kind_t           w_kind;
  logic            w_take;
  logic            w_imm;
  logic [OP_W-1:0] w_op;
  logic [OP_W-1:0] w_ext;
  logic [OP_W-1:0] w_fn;
  logic            w_ir_en, w_pc_en, w_mem_we;
  logic            w_reg_we, w_flags_we;
  logic            w_unused;

  assign w_op     = ir[15:12];
  assign w_ext    = ir[7:4];
  assign w_imm    = (w_op != OP_REG);
  assign w_fn     = w_imm ? w_op : w_ext;
  assign w_kind   = decode_kind(ir);
  assign w_unused = ^ir[3:0];

  cond_eval u_cond (
    .i_cond  (ir[11:8]),
    .i_flags (flags),
    .o_take  (w_take)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_ir_en       = 1'b0;
    w_pc_en       = 1'b0;
    w_mem_we      = 1'b0;
    w_reg_we      = 1'b0;
    w_flags_we    = 1'b0;
    pc_sel        = PC_INC;
    addr_sel      = 1'b0;
    wb_sel        = WB_ALU;
    alu_op        = ALU_NOP;
    b_sel         = 1'b0;
    sign_ext      = 1'b0;
    shift_dir     = 1'b0;
    shift_amt_sel = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_ir_en = run;
        if (run) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (w_kind)
          K_LOAD:  w_next = S_MEM;
          K_STOR:  w_next = S_STORE;
          K_BCOND, K_JCOND: w_next = S_BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
          K_ILL:   w_next = S_HALT;
`endif
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
        case (w_kind)
          K_ALU: begin
            alu_op     = alu_code(w_fn);
            b_sel      = w_imm;
            sign_ext   = w_imm &&
                         (is_arith(w_fn) || w_fn == FN_MOV);
            w_reg_we   = (w_fn != FN_CMP);
            w_flags_we = is_arith(w_fn);
          end
          K_SHIFT: begin
            wb_sel        = WB_SHF;
            w_reg_we      = 1'b1;
            shift_amt_sel = (w_ext != EXT_LSH);
            shift_dir     = (w_ext != EXT_LSH) && ir[4];
          end
          K_LUI: begin
            wb_sel   = WB_LUI;
            w_reg_we = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        addr_sel = 1'b1;
        w_next   = S_WB;
      end
      S_WB: begin
        addr_sel = 1'b1;
        wb_sel   = WB_MEM;
        w_reg_we = 1'b1;
        w_pc_en  = 1'b1;
        w_next   = S_FETCH;
      end
      S_STORE: begin
        addr_sel = 1'b1;
        w_mem_we = 1'b1;
        w_pc_en  = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        w_pc_en = 1'b1;
        w_next  = S_FETCH;
        if (w_take)
          pc_sel = (w_kind == K_BCOND) ? PC_DISP : PC_REG;
      end
      S_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_next = S_HALT;
`else
        w_next = S_FETCH;
`endif
      end
    endcase
  end

  // Strobes are gated so a reset landing mid-instruction commits nothing.
  assign ir_en    = w_ir_en    & ~reset;
  assign pc_en    = w_pc_en    & ~reset;
  assign mem_we   = w_mem_we   & ~reset;
  assign reg_we   = w_reg_we   & ~reset;
  assign flags_we = w_flags_we & ~reset;
  assign state    = r_state;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (r_state == S_HALT);
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected control words
// are queued as stimulus is driven and compared at negedge.
module tb_cpu_controller;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic [1:0] pc_sel;
    logic       addr_sel;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic [3:0] alu_op;
    logic       b_sel;
    logic       sign_ext;
    logic       shift_dir;
    logic       shift_amt_sel;
    logic       flags_we;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [2:0] st;
    ctl_t       ctl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] ir;
  logic [4:0]  flags;
  logic        ir_en, pc_en, addr_sel, mem_we, reg_we;
  logic [1:0]  pc_sel, wb_sel;
  logic [3:0]  alu_op;
  logic        b_sel, sign_ext, shift_dir, shift_amt_sel;
  logic        flags_we;
  logic [2:0]  state;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .flags(flags),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .addr_sel(addr_sel), .mem_we(mem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_op(alu_op), .b_sel(b_sel),
    .sign_ext(sign_ext), .shift_dir(shift_dir),
    .shift_amt_sel(shift_amt_sel), .flags_we(flags_we),
    .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic take(input logic [3:0] cd,
                                input logic [4:0] f);
    logic c, l, fl, z, n;
    {c, l, fl, z, n} = f;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return fl;
      4'd9:  return !fl;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t model(input logic [2:0] st,
      input logic [15:0] i, input logic [4:0] f,
      input logic rs, input logic rn);
    ctl_t c;
    logic [3:0] op, ex;
    c  = '0;
    op = i[15:12];
    ex = i[7:4];
    case (st)
      3'd0: c.ir_en = rn;
      3'd2: begin
        c.pc_en = 1'b1;
        if (op == 4'h0 && ex inside {1, 2, 3, 5, 9, 11, 13}) begin
          c.alu_op   = ex;
          c.reg_we   = (ex != 4'hB);
          c.flags_we = ex inside {5, 9, 11};
        end else if (op inside {1, 2, 3, 5, 9, 11, 13}) begin
          c.alu_op   = op;
          c.b_sel    = 1'b1;
          c.sign_ext = op inside {5, 9, 11, 13};
          c.reg_we   = (op != 4'hB);
          c.flags_we = op inside {5, 9, 11};
        end else if (op == 4'h8 && ex == 4'h4) begin
          c.wb_sel = 2'b01;
          c.reg_we = 1'b1;
        end else if (op == 4'h8 && ex inside {0, 1}) begin
          c.wb_sel        = 2'b01;
          c.reg_we        = 1'b1;
          c.shift_amt_sel = 1'b1;
          c.shift_dir     = i[4];
        end else if (op == 4'hF) begin
          c.wb_sel = 2'b11;
          c.reg_we = 1'b1;
        end
      end
      3'd3: c.addr_sel = 1'b1;
      3'd4: begin
        c.addr_sel = 1'b1;
        c.wb_sel   = 2'b10;
        c.reg_we   = 1'b1;
        c.pc_en    = 1'b1;
      end
      3'd5: begin
        c.addr_sel = 1'b1;
        c.mem_we   = 1'b1;
        c.pc_en    = 1'b1;
      end
      3'd6: begin
        c.pc_en = 1'b1;
        if (take(i[11:8], f))
          c.pc_sel = (op == 4'hC) ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
    if (rs) begin
      c.ir_en    = 1'b0;
      c.pc_en    = 1'b0;
      c.mem_we   = 1'b0;
      c.reg_we   = 1'b0;
      c.flags_we = 1'b0;
    end
    return c;
  endfunction

  function automatic logic [2:0] after_decode(input logic [15:0] i);
    if (i[15:12] == 4'hC) return 3'd6;
    if (i[15:12] == 4'h4) begin
      if (i[7:4] == 4'h0) return 3'd3;
      if (i[7:4] == 4'h4) return 3'd5;
      if (i[7:4] == 4'hC) return 3'd6;
    end
    return 3'd2;
  endfunction

  task automatic cyc(input string tag, input logic [2:0] st,
      input logic [15:0] i, input logic [4:0] f,
      input logic rs, input logic rn);
    exp_t e;
    @(posedge clk);
    #1;
    ir    = i;
    flags = f;
    reset = rs;
    run   = rn;
    e.tag = tag;
    e.st  = st;
    e.ctl = model(st, i, f, rs, rn);
    q.push_back(e);
  endtask

  task automatic do_instr(input string tag, input logic [15:0] i,
                          input logic [4:0] f);
    logic [2:0] s;
    s = after_decode(i);
    cyc({tag, ".fetch"}, 3'd0, i, f, 1'b0, 1'b1);
    cyc({tag, ".decode"}, 3'd1, i, f, 1'b0, 1'b1);
    cyc({tag, ".s", $sformatf("%0d", s)}, s, i, f, 1'b0, 1'b1);
    if (s == 3'd3)
      cyc({tag, ".wb"}, 3'd4, i, f, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      ctl_t g;
      e = q.pop_front();
      g = {ir_en, pc_en, pc_sel, addr_sel, mem_we, reg_we, wb_sel,
           alu_op, b_sel, sign_ext, shift_dir, shift_amt_sel,
           flags_we};
      chk({e.tag, ".state"}, 32'(state), 32'(e.st));
      chk({e.tag, ".ctl"}, 32'(g), 32'(e.ctl));
    end
  end

  initial begin
    logic [4:0] fr;
    reset = 1'b1;
    run   = 1'b1;
    ir    = 16'h0000;
    flags = 5'b0;
    @(posedge clk);
    cyc("rst0", 3'd0, 16'h0152, 5'b0, 1'b1, 1'b1);
    cyc("rst1", 3'd0, 16'h0152, 5'b0, 1'b1, 1'b1);

    do_instr("add",   16'h0152, 5'b0);
    do_instr("addi",  16'h53FF, 5'b0);
    do_instr("andi",  16'h13FF, 5'b0);
    do_instr("cmpi",  16'hB3FF, 5'b0);
    do_instr("cmp",   16'h01B2, 5'b0);
    do_instr("sub",   16'h0192, 5'b0);
    do_instr("xor",   16'h0132, 5'b0);
    do_instr("movi",  16'hD305, 5'b0);
    do_instr("lui",   16'hF312, 5'b0);
    do_instr("load",  16'h4405, 5'b0);
    do_instr("stor",  16'h4445, 5'b0);
    do_instr("beq_t", 16'hC0FE, 5'b00010);
    do_instr("beq_n", 16'hC0FE, 5'b00000);
    do_instr("juc",   16'h4EC7, 5'b0);
    do_instr("jnv",   16'h4FC7, 5'b11111);
    do_instr("lshi",  16'h8102, 5'b0);
    do_instr("lshir", 16'h8112, 5'b0);
    do_instr("lsh",   16'h8142, 5'b0);
    do_instr("ill6",  16'h6123, 5'b0);
    do_instr("ill0",  16'h0000, 5'b0);
    do_instr("illls", 16'h4123, 5'b0);
    do_instr("illsh", 16'h8152, 5'b0);

    for (int c = 0; c < 16; c++) begin
      fr = 5'($urandom);
      do_instr($sformatf("b%0d", c), {4'hC, 4'(c), 8'h10}, fr);
      fr = 5'($urandom);
      do_instr($sformatf("j%0d", c), {4'h4, 4'(c), 8'hC3}, fr);
    end

    cyc("rl.fetch", 3'd0, 16'h4405, 5'b0, 1'b0, 1'b1);
    cyc("rl.decode", 3'd1, 16'h4405, 5'b0, 1'b0, 1'b1);
    cyc("rl.mem", 3'd3, 16'h4405, 5'b0, 1'b1, 1'b1);
    cyc("re.fetch", 3'd0, 16'h0152, 5'b0, 1'b0, 1'b1);
    cyc("re.decode", 3'd1, 16'h0152, 5'b0, 1'b0, 1'b1);
    cyc("re.exec", 3'd2, 16'h0152, 5'b0, 1'b1, 1'b1);
    cyc("rs.fetch", 3'd0, 16'h4445, 5'b0, 1'b0, 1'b1);
    cyc("rs.decode", 3'd1, 16'h4445, 5'b0, 1'b0, 1'b1);
    cyc("rs.store", 3'd5, 16'h4445, 5'b0, 1'b1, 1'b1);
    cyc("rf.fetch", 3'd0, 16'h0152, 5'b0, 1'b1, 1'b1);

    cyc("run.fetch", 3'd0, 16'h0152, 5'b0, 1'b0, 1'b1);
    cyc("run.decode", 3'd1, 16'h0152, 5'b0, 1'b0, 1'b0);
    cyc("run.exec", 3'd2, 16'h0152, 5'b0, 1'b0, 1'b0);
    cyc("idle0", 3'd0, 16'h0152, 5'b0, 1'b0, 1'b0);
    cyc("idle1", 3'd0, 16'h0152, 5'b0, 1'b0, 1'b0);
    do_instr("resume", 16'h53FF, 5'b0);
    do_instr("final",  16'h0152, 5'b0);

    @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Multi-cycle control FSM for the 16-bit CR16-style datapath: register file, ALU, `signextend` and `shifter` units, PC and unified memory.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every mux select, write enable and function code in the datapath; holds no data itself.
- Sits in the CPU top level between the instruction register/flag register and the datapath.

Parameters:
- `OP_W`, 4, width of the opcode and op-extension fields.
- `FLAG_W`, 5, width of the flag bus {C,L,F,Z,N}.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; single clock domain.
- `run`  in  1  when low, FSM idles in `S_FETCH` with no strobes.
- `ir`  in  16  instruction register contents: [15:12] op, [11:8] Rdest/cond, [7:4] ext, [3:0] Rsrc/imm.
- `flags`  in  5  {C,L,F,Z,N} from the datapath flag register.
- `ir_en`  out  1  latch memory read data into IR.
- `pc_en`  out  1  update PC.
- `pc_sel`  out  2  00 PC+1, 01 PC+signext(disp8), 10 Rsrc.
- `addr_sel`  out  1  memory address: 0 PC, 1 Rsrc.
- `mem_we`  out  1  memory write (data = Rdest).
- `reg_we`  out  1  register-file write to Rdest.
- `wb_sel`  out  2  00 ALU, 01 shifter, 10 memory, 11 {imm8,8'h00} (LUI).
- `alu_op`  out  4  ALU function code (from the package).
- `b_sel`  out  1  ALU B operand: 0 Rsrc, 1 extended immediate.
- `sign_ext`  out  1  drives `signextend.sign`.
- `shift_dir`  out  1  drives `shifter.dir`: 0 left, 1 right.
- `shift_amt_sel`  out  1  shift amount: 0 Rsrc, 1 imm4 zero-extended.
- `flags_we`  out  1  flag register update.
- `state`  out  3  current state, for debug.

Behaviour:
- States:
  - `S_FETCH` (0): `ir_en` = `run`, `addr_sel` = 0. Goes to `S_DECODE` if `run`, else stays.
  - `S_DECODE` (1): no strobes.
    - LOAD → `S_MEM`; STOR → `S_STORE`; Bcond/Jcond → `S_BRANCH`; all other instructions → `S_EXEC`.
  - `S_EXEC` (2): `reg_we` = 1 (0 for CMP/CMPI), `flags_we` = 1 for arithmetic/compare, `pc_en` = 1, `pc_sel` = 00. → `S_FETCH`.
  - `S_MEM` (3): `addr_sel` = 1; synchronous RAM read cycle. → `S_WB`.
  - `S_WB` (4): `addr_sel` = 1, `wb_sel` = 10, `reg_we` = 1, `pc_en` = 1. → `S_FETCH`.
  - `S_STORE` (5): `addr_sel` = 1, `mem_we` = 1, `pc_en` = 1. → `S_FETCH`.
  - `S_BRANCH` (6): `pc_en` = 1. `pc_sel` = 01 (Bcond) or 10 (Jcond) if the condition holds, else 00. → `S_FETCH`.
  - `S_HALT` (7): only reachable with the optional feature enabled.
- Latency: ALU/shift/branch/store take 3 cycles; load takes 4.
- Outputs are combinational from `state` and `ir` (Moore by state, `ir`-decoded fields).
- Any output not listed for a state is 0.
- Immediate decode:
  - ADDI/SUBI/CMPI/MOVI: `sign_ext` = 1.
  - ANDI/ORI/XORI: `sign_ext` = 0.
  - All immediates: `b_sel` = 1.
- Shifts:
  - LSH (op 1000, ext 0100): `shift_amt_sel` = 0, `shift_dir` = 0.
  - LSHI (op 1000, ext 000s): `shift_amt_sel` = 1, `shift_dir` = ir[4].
  - Both: `wb_sel` = 01, `flags_we` = 0.
- LUI: `wb_sel` = 11.
- Conditions use CR16 codes:
  - EQ Z, NE !Z, CS C, CC !C, HI L, LS !L, GT N, LE !N.
  - FS F, FC !F, LO !L&!Z, HS L|Z, LT !N&!Z, GE N|Z.
  - UC (1110) always; 1111 never.
- Reset:
  - Next edge forces `S_FETCH`, regardless of the current state (mid-load, mid-store).
  - While `reset` = 1, all enables (`ir_en`, `pc_en`, `mem_we`, `reg_we`, `flags_we`) are gated to 0.
- `run`:
  - Deasserting `run` mid-instruction does not stall; the instruction completes.
  - The FSM then idles in `S_FETCH`.
- Undefined op/ext without the optional feature: executes as NOP through `S_EXEC` with `reg_we` = 0 and `flags_we` = 0; PC still advances.

Optional Feature:
- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - Undefined encoding in `S_DECODE` → `S_HALT`.
  - `S_HALT` holds with all strobes 0 until `reset`.
  - Extra output `illegal` (1 bit) = 1 while in `S_HALT`.
- Undefined: NOP behaviour above; no `illegal` port.

Decomposition:
- Package `cpu_ctrl_pkg`:
  - state encodings;
  - opcode/ext constants (ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101, LUI 1111, SHIFT 1000, LDST 0100, LOAD ext 0000, STOR ext 0100, JCOND ext 1100, BCOND 1100);
  - `alu_op` codes; `wb_sel`/`pc_sel` encodings; condition codes.
- One sub-module, `cond_eval`: combinational (cond[3:0], flags) → take.

Test Plan:
- Reset 2 cycles, `run` = 1:
  - During reset: `state` = 0, all enables 0.
  - First cycle after: `ir_en` = 1.
- ADD R1,R2 (0x0152): `S_FETCH`, `S_DECODE`, `S_EXEC`.
  - `S_EXEC` shows `alu_op` = ADD, `b_sel` = 0, `reg_we` = 1, `flags_we` = 1, `pc_en` = 1.
  - Back in `S_FETCH` on cycle 4.
- ADDI R3,#-1 (0x53FF) → `sign_ext` = 1, `b_sel` = 1. ANDI 0x13FF → `sign_ext` = 0. CMPI 0xB3FF → `reg_we` = 0, `flags_we` = 1.
- LOAD R4,[R5] (0x4405): 4 cycles.
  - `S_MEM` `addr_sel` = 1.
  - `S_WB` `wb_sel` = 10, `reg_we` = 1.
  - STOR 0x4445 → `mem_we` = 1 for exactly one cycle.
- BEQ 0xC0FE:
  - Z = 1 → `pc_sel` = 01.
  - Z = 0 → `pc_sel` = 00.
  - JUC R7 (0x4EC7) → `pc_sel` = 10.
- LSHI 0x8102 → `wb_sel` = 01, `shift_dir` = 0, `shift_amt_sel` = 1. 0x8112 → `shift_dir` = 1.
- Reset asserted in `S_MEM` → `reg_we` never pulses; `S_FETCH` next cycle.
